// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction controller.
//   txn_state_t : transaction FSM states (IDLE, LAUNCH, RUN, DONE)
//   I2C_ADDR_W  : slave address width
//   I2C_BYTE_W  : data byte width
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } txn_state_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (flushes pointers)
//   push, push_data   : write side; push while full is dropped unless a pop
//                       happens on the same cycle
//   pop, pop_data     : read side; pop_data always shows the head entry,
//                       pop while empty is ignored
//   empty, count      : occupancy status
module i2c_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same cycle.
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/i2c_txn_ctrl.sv
// I2C transaction controller sitting in front of the byte-level I2C master.
// Accepts a host command, stages write bytes in a TX FIFO, runs the master's
// enable / data_next handshake and collects read bytes in an RX FIFO.
// Ports:
//   clk, rst                        : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_addr,
//   cmd_rw, cmd_len                 : host command handshake
//   wr_data/wr_valid/wr_ready       : TX FIFO push
//   rd_data/rd_valid/rd_ready       : RX FIFO pop (first-word fall-through)
//   done, err, busy                 : completion pulse, sticky status, activity
//   m_addr, m_rw, m_tx_data,
//   m_i2c_en, m_data_valid,
//   m_read_last                     : drive the master
//   m_data_next, m_rx_data, m_ready : from the master
module i2c_txn_ctrl
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [I2C_BYTE_W-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [I2C_BYTE_W-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [I2C_ADDR_W-1:0] m_addr,
    output logic                  m_rw,
    output logic [I2C_BYTE_W-1:0] m_tx_data,
    output logic                  m_i2c_en,
    output logic                  m_data_valid,
    output logic                  m_read_last,
    input  logic                  m_data_next,
    input  logic [I2C_BYTE_W-1:0] m_rx_data,
    input  logic                  m_ready
);

    txn_state_t            state, state_nxt;
    logic [I2C_ADDR_W-1:0] addr_q;
    logic                  rw_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt;
    logic [LEN_W-1:0]      rem;
    logic                  reject_q;
    logic                  err_q;
    logic                  done_q;
    logic                  init_q;
    logic                  dn_p1;
    logic                  rdy_p1;

    logic                  dn_rise;
    logic                  rdy_rise;
    logic                  accept;
    logic                  reject;
    logic                  bad_cmd;
    logic                  launch_wr;
    logic                  cnt_inc;

    logic                  tx_push, tx_pop, tx_empty, tx_full;
    logic [I2C_BYTE_W-1:0] tx_head;
    logic [LEN_W-1:0]      tx_count;
    logic                  rx_push, rx_pop, rx_empty;
    logic [LEN_W-1:0]      rx_count;
    logic [LEN_W-1:0]      rx_free;

    // ---------------- FIFOs ----------------
    assign tx_full  = (tx_count == LEN_W'(FIFO_DEPTH));
    assign wr_ready = init_q && (!tx_full || tx_pop);
    assign tx_push  = wr_valid && wr_ready;
    assign rx_pop   = rd_ready && !rx_empty;
    assign rx_free  = LEN_W'(FIFO_DEPTH) - rx_count;

    i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(I2C_BYTE_W)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (wr_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    i2c_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(I2C_BYTE_W)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (m_rx_data),
        .pop       (rx_pop),
        .pop_data  (rd_data),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // ---------------- edge detection (p1 = previous cycle) ----------------
    assign dn_rise  = m_data_next && !dn_p1;
    assign rdy_rise = m_ready && !rdy_p1;

    // A command that cannot complete is turned around without touching the bus.
    assign bad_cmd = (cmd_len == '0) ||
                     (cmd_len > LEN_W'(FIFO_DEPTH)) ||
                     (!cmd_rw && (tx_count < cmd_len)) ||
                     ( cmd_rw && (rx_free  < cmd_len));

    // ---------------- FSM next state / strobes ----------------
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        launch_wr = 1'b0;
        cnt_inc   = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = m_ready;
                if (cmd_valid && m_ready) begin
                    accept    = 1'b1;
                    reject    = bad_cmd;
                    state_nxt = bad_cmd ? DONE : LAUNCH;
                end
            end
            LAUNCH: begin
                // The master has latched the command (and first write byte)
                // once it drops m_ready.
                if (!m_ready) begin
                    state_nxt = RUN;
                    if (!rw_q) begin
                        tx_pop    = 1'b1;
                        launch_wr = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rdy_rise) begin
                    state_nxt = DONE;
                    // The last read byte arrives without a data_next strobe.
                    if (rw_q && (rem == LEN_W'(1))) begin
                        rx_push = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end else if (dn_rise && (rem != '0)) begin
                    cnt_inc = 1'b1;
                    if (rw_q) rx_push = 1'b1;
                    else      tx_pop  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- state and counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            len_q    <= '0;
            cnt      <= '0;
            rem      <= '0;
            reject_q <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            init_q   <= 1'b0;
            dn_p1    <= 1'b0;
            rdy_p1   <= 1'b0;
        end else begin
            state  <= state_nxt;
            init_q <= 1'b1;
            dn_p1  <= m_data_next;
            rdy_p1 <= m_ready;
            done_q <= 1'b0;
            if (accept) begin
                addr_q   <= cmd_addr;
                rw_q     <= cmd_rw;
                len_q    <= cmd_len;
                rem      <= cmd_len;
                cnt      <= '0;
                reject_q <= reject;
                err_q    <= 1'b0;
            end
            if (launch_wr) begin
                cnt <= LEN_W'(1);
                rem <= len_q - 1'b1;
            end
            if (cnt_inc) begin
                cnt <= cnt + 1'b1;
                rem <= rem - 1'b1;
            end
            // Short count means a NACK ended the transfer early.
            if (state == DONE) begin
                done_q <= 1'b1;
                err_q  <= reject_q || (cnt != len_q);
            end
        end
    end

    // ---------------- outputs ----------------
    assign busy         = (state != IDLE);
    assign done         = done_q;
    assign err          = err_q;
    assign m_addr       = addr_q;
    assign m_rw         = rw_q;
    assign m_i2c_en     = (state == LAUNCH);
    assign m_tx_data    = tx_empty ? '0 : tx_head;
    assign m_data_valid = (state == RUN) && !rw_q && (rem != '0) && !tx_empty;
    assign m_read_last  = (state == RUN) && rw_q && (rem == LEN_W'(1));
    assign rd_valid     = !rx_empty;

endmodule

// File: tb/tb_i2c_txn_ctrl.sv
module tb_i2c_txn_ctrl;

    logic       clk, rst;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data, rd_data;
    logic       wr_valid, wr_ready, rd_valid, rd_ready;
    logic       done, err, busy;
    logic [6:0] m_addr;
    logic       m_rw, m_i2c_en, m_data_valid, m_read_last;
    logic [7:0] m_tx_data, m_rx_data;
    logic       m_data_next, m_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // master model observations
    logic [7:0] bus_q[$];
    logic [7:0] exp_q[$];
    logic       rl_q[$];
    logic [7:0] rvals[9];
    logic [6:0] mst_addr;
    logic       mst_rw;
    logic       mst_timeout;
    logic       obs_wr_ready;
    int         obs_cnt;

    i2c_txn_ctrl #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err), .busy(busy),
        .m_addr(m_addr), .m_rw(m_rw), .m_tx_data(m_tx_data), .m_i2c_en(m_i2c_en),
        .m_data_valid(m_data_valid), .m_read_last(m_read_last),
        .m_data_next(m_data_next), .m_rx_data(m_rx_data), .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 4 && !wr_ready; i++) tick();
        wr_data  = b;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic issue_cmd(input logic [6:0] a, input logic rw, input logic [3:0] len,
                             output bit acc);
        acc       = 1'b0;
        cmd_addr  = a;
        cmd_rw    = rw;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                tick();
                acc = 1'b1;
                break;
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    // Behavioural byte-level master: 8-cycle address phase, 6-cycle bytes,
    // data_next held 3 cycles, first write byte latched at start.
    task automatic master_serve(input bit nack, input int abort_at, input bit push_on_pop);
        bit         got_en;
        logic [7:0] cur;
        got_en      = 1'b0;
        mst_timeout = 1'b0;
        bus_q.delete();
        rl_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (m_i2c_en) begin got_en = 1'b1; break; end
            tick();
        end
        if (!got_en) begin mst_timeout = 1'b1; return; end
        tick();
        tick();
        mst_addr = m_addr;
        mst_rw   = m_rw;
        cur      = m_tx_data;
        m_ready  = 1'b0;
        if (push_on_pop) begin
            wr_data  = 8'h99;
            wr_valid = 1'b1;
            #1;
            obs_wr_ready = wr_ready;
        end
        tick();
        if (push_on_pop) begin
            wr_valid = 1'b0;
            obs_cnt  = int'(dut.u_tx.count);
        end
        repeat (8) tick();
        if (nack) begin m_ready = 1'b1; return; end
        if (!mst_rw) begin
            bus_q.push_back(cur);
            for (int nb = 0; nb < 16; nb++) begin
                for (int c = 0; c < 6; c++) begin
                    tick();
                    if (abort_at > 0 && nb == 0 && c == abort_at) return;
                end
                if (!m_data_valid) break;
                cur         = m_tx_data;
                m_data_next = 1'b1;
                repeat (3) tick();
                m_data_next = 1'b0;
                bus_q.push_back(cur);
            end
            m_ready = 1'b1;
        end else begin
            for (int nb = 0; nb < 9; nb++) begin
                repeat (6) tick();
                m_rx_data = rvals[nb];
                rl_q.push_back(m_read_last);
                if (m_read_last) break;
                m_data_next = 1'b1;
                repeat (3) tick();
                m_data_next = 1'b0;
            end
            m_ready = 1'b1;
        end
    endtask

    // done sampled 1, 2 and 3 cycles after m_ready rose; err with the pulse.
    task automatic finish_txn(output bit d0, output bit d1, output bit d2, output bit e);
        tick(); d0 = done;
        tick(); d1 = done; e = err;
        tick(); d2 = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 0; cmd_addr = 0; cmd_rw = 0; cmd_len = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        m_data_next = 0; m_rx_data = 0; m_ready = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({m_i2c_en, m_data_valid, m_read_last, done, err, busy, rd_valid, wr_ready} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000000", {m_i2c_en, m_data_valid, m_read_last, done, err, busy, rd_valid, wr_ready});
        end
        n_checks++;
        if ({m_addr, m_rw, m_tx_data} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data: got %h required 0000", {m_addr, m_rw, m_tx_data});
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready_hi: got %b required 1", cmd_ready); end
        m_ready = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready_lo: got %b required 0", cmd_ready); end
        m_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL release_wr_ready0: got %b required 0", wr_ready); end
        tick();
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL release_wr_ready1: got %b required 1", wr_ready); end
    endtask

    task automatic test_write();
        bit acc, d0, d1, d2, e;
        push_byte(8'hA5);
        push_byte(8'h3C);
        issue_cmd(7'h50, 1'b0, 4'd2, acc);
        n_checks++;
        if (m_i2c_en !== 1'b1) begin n_fail++; $display("FAIL wr_en_latency: got %b required 1", m_i2c_en); end
        master_serve(1'b0, 0, 1'b0);
        n_checks++;
        if ({mst_timeout, mst_addr, mst_rw} !== {1'b0, 7'h50, 1'b0}) begin
            n_fail++; $display("FAIL wr_addr: got to=%b addr=%h rw=%b required to=0 addr=50 rw=0", mst_timeout, mst_addr, mst_rw);
        end
        exp_q = '{8'hA5, 8'h3C};
        n_checks++;
        if (!q_eq(bus_q, exp_q)) begin n_fail++; $display("FAIL wr_bus: got %p required %p", bus_q, exp_q); end
        finish_txn(d0, d1, d2, e);
        n_checks++;
        if ({d0, d1, d2, e} !== 4'b0100) begin n_fail++; $display("FAIL wr_done_err: got done=%b%b%b err=%b required 010 err=0", d0, d1, d2, e); end
        n_checks++;
        if (dut.u_tx.count !== 4'd0) begin n_fail++; $display("FAIL wr_tx_empty: got %0d required 0", dut.u_tx.count); end
    endtask

    task automatic test_read();
        bit acc, d0, d1, d2, e;
        rvals[0] = 8'h11; rvals[1] = 8'h22; rvals[2] = 8'h33;
        issue_cmd(7'h48, 1'b1, 4'd3, acc);
        master_serve(1'b0, 0, 1'b0);
        n_checks++;
        if (rl_q.size() != 3 || {rl_q[0], rl_q[1], rl_q[2]} !== 3'b001) begin
            n_fail++; $display("FAIL rd_read_last: got %p required 0,0,1", rl_q);
        end
        finish_txn(d0, d1, d2, e);
        n_checks++;
        if ({d0, d1, d2, e, mst_rw} !== 5'b01001) begin n_fail++; $display("FAIL rd_done_err: got done=%b%b%b err=%b rw=%b required 010 err=0 rw=1", d0, d1, d2, e, mst_rw); end
        rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({rd_valid, rd_data} !== {1'b1, rvals[k]}) begin
                n_fail++; $display("FAIL rd_pop%0d: got v=%b d=%h required v=1 d=%h", k, rd_valid, rd_data, rvals[k]);
            end
            tick();
        end
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_empty: got %b required 0", rd_valid); end
    endtask

    task automatic test_addr_nack();
        bit acc, d0, d1, d2, e;
        push_byte(8'hA5);
        push_byte(8'h3C);
        issue_cmd(7'h50, 1'b0, 4'd2, acc);
        master_serve(1'b1, 0, 1'b0);
        finish_txn(d0, d1, d2, e);
        n_checks++;
        if ({d1, e} !== 2'b11) begin n_fail++; $display("FAIL nack_err: got done=%b err=%b required 1 1", d1, e); end
        n_checks++;
        if ({dut.u_tx.count, m_tx_data} !== {4'd1, 8'h3C}) begin
            n_fail++; $display("FAIL nack_tx: got cnt=%0d head=%h required cnt=1 head=3c", dut.u_tx.count, m_tx_data);
        end
    endtask

    task automatic test_rejects();
        bit acc, d0, d1, d2, e, en_seen;
        push_byte(8'h77);
        // write len=4 with only 2 staged
        issue_cmd(7'h50, 1'b0, 4'd4, acc);
        en_seen = m_i2c_en;
        tick();
        en_seen = en_seen | m_i2c_en;
        n_checks++;
        if ({acc, done, err, en_seen} !== 4'b1110) begin
            n_fail++; $display("FAIL rej_short_tx: got acc=%b done=%b err=%b en=%b required 1 1 1 0", acc, done, err, en_seen);
        end
        repeat (3) tick();
        n_checks++;
        if ({err, busy} !== 2'b10) begin n_fail++; $display("FAIL rej_err_held: got err=%b busy=%b required 1 0", err, busy); end
        // read len=9 exceeds depth
        issue_cmd(7'h48, 1'b1, 4'd9, acc);
        tick();
        n_checks++;
        if ({done, err, m_i2c_en} !== 3'b110) begin n_fail++; $display("FAIL rej_len9: got done=%b err=%b en=%b required 1 1 0", done, err, m_i2c_en); end
        // len=0
        issue_cmd(7'h48, 1'b1, 4'd0, acc);
        tick();
        n_checks++;
        if ({done, err} !== 2'b11) begin n_fail++; $display("FAIL rej_len0: got done=%b err=%b required 1 1", done, err); end
        // legal write drains the two staged bytes and clears err on accept
        issue_cmd(7'h51, 1'b0, 4'd2, acc);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_accept: got %b required 0", err); end
        master_serve(1'b0, 0, 1'b0);
        finish_txn(d0, d1, d2, e);
        exp_q = '{8'h3C, 8'h77};
        n_checks++;
        if (!q_eq(bus_q, exp_q) || {d1, e} !== 2'b10) begin
            n_fail++; $display("FAIL drain_write: got %p done=%b err=%b required %p done=1 err=0", bus_q, d1, e, exp_q);
        end
    endtask

    task automatic test_fifo_full();
        bit acc, d0, d1, d2, e;
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        n_checks++;
        if ({wr_ready, dut.u_tx.count} !== {1'b0, 4'd8}) begin
            n_fail++; $display("FAIL full_ready: got rdy=%b cnt=%0d required rdy=0 cnt=8", wr_ready, dut.u_tx.count);
        end
        wr_data = 8'hEE; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        n_checks++;
        if (dut.u_tx.count !== 4'd8) begin n_fail++; $display("FAIL full_drop9: got %0d required 8", dut.u_tx.count); end
        issue_cmd(7'h52, 1'b0, 4'd8, acc);
        master_serve(1'b0, 0, 1'b1);
        n_checks++;
        if ({obs_wr_ready, obs_cnt} !== {1'b1, 32'd8}) begin
            n_fail++; $display("FAIL full_push_pop: got rdy=%b cnt=%0d required rdy=1 cnt=8", obs_wr_ready, obs_cnt);
        end
        finish_txn(d0, d1, d2, e);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        n_checks++;
        if (!q_eq(bus_q, exp_q) || {d1, e} !== 2'b10) begin
            n_fail++; $display("FAIL full_bus8: got %p done=%b err=%b required %p done=1 err=0", bus_q, d1, e, exp_q);
        end
        issue_cmd(7'h52, 1'b0, 4'd1, acc);
        master_serve(1'b0, 0, 1'b0);
        finish_txn(d0, d1, d2, e);
        exp_q = '{8'h99};
        n_checks++;
        if (!q_eq(bus_q, exp_q) || {d1, e} !== 2'b10) begin
            n_fail++; $display("FAIL full_leftover: got %p done=%b err=%b required %p done=1 err=0", bus_q, d1, e, exp_q);
        end
    endtask

    task automatic test_wrap();
        bit         acc, d0, d1, d2, e, ok;
        logic [7:0] got_q[$];
        for (int i = 0; i < 20; i++) begin
            exp_q.delete();
            for (int k = 0; k < 3; k++) exp_q.push_back(8'(i * 16 + k));
            if (i % 2 == 0) begin
                for (int k = 0; k < 3; k++) push_byte(exp_q[k]);
                issue_cmd(7'(8'h20 + 8'(i)), 1'b0, 4'd3, acc);
                master_serve(1'b0, 0, 1'b0);
                finish_txn(d0, d1, d2, e);
                got_q = bus_q;
            end else begin
                for (int k = 0; k < 3; k++) rvals[k] = exp_q[k];
                issue_cmd(7'(8'h20 + 8'(i)), 1'b1, 4'd3, acc);
                master_serve(1'b0, 0, 1'b0);
                finish_txn(d0, d1, d2, e);
                got_q.delete();
                rd_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    if (rd_valid) got_q.push_back(rd_data);
                    tick();
                end
                rd_ready = 1'b0;
            end
            ok = q_eq(got_q, exp_q) && d1 && !e && (mst_addr == 7'(8'h20 + 8'(i)));
            n_checks++;
            if (ok !== 1'b1) begin
                n_fail++; $display("FAIL wrap_txn%0d: got %p done=%b err=%b addr=%h required %p done=1 err=0", i, got_q, d1, e, mst_addr, exp_q);
            end
        end
    endtask

    task automatic test_async_reset();
        bit acc, d0, d1, d2, e, done_seen;
        push_byte(8'hA5);
        push_byte(8'h3C);
        issue_cmd(7'h50, 1'b0, 4'd2, acc);
        master_serve(1'b0, 3, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy_before: got %b required 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, rd_valid, m_i2c_en, done, dut.u_tx.count} !== {4'b0000, 4'd0}) begin
            n_fail++; $display("FAIL arst_state: got busy=%b rdv=%b en=%b done=%b txcnt=%0d required 0 0 0 0 0", busy, rd_valid, m_i2c_en, done, dut.u_tx.count);
        end
        m_ready = 1'b1;
        m_data_next = 1'b0;
        done_seen = 1'b0;
        repeat (2) begin tick(); done_seen = done_seen | done; end
        rst = 1'b0;
        repeat (2) begin tick(); done_seen = done_seen | done; end
        n_checks++;
        if (done_seen !== 1'b0) begin n_fail++; $display("FAIL arst_no_done: got %b required 0", done_seen); end
        push_byte(8'hC3);
        push_byte(8'h5A);
        issue_cmd(7'h50, 1'b0, 4'd2, acc);
        master_serve(1'b0, 0, 1'b0);
        finish_txn(d0, d1, d2, e);
        exp_q = '{8'hC3, 8'h5A};
        n_checks++;
        if (!q_eq(bus_q, exp_q) || {d0, d1, d2, e} !== 4'b0100) begin
            n_fail++; $display("FAIL arst_recover: got %p done=%b%b%b err=%b required %p done=010 err=0", bus_q, d0, d1, d2, e, exp_q);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_rejects();
        test_fifo_full();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
